// File: rtl/drum_pkg.sv
// Shared constants for the DRUM multiplier and the state encoding of the scheduler that time-shares it.
package drum_pkg;

   localparam int K_DEF = 3;
   localparam int N_DEF = 8;
   localparam int M_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_RSP  = 2'd2
   } state_e;

   // Plain vector constants so state registers stay ordinary logic for older tooling.
   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] MUL  = ST_MUL;
   localparam logic [1:0] RSP  = ST_RSP;

endpackage

// File: rtl/drum.sv
// DRUM approximate signed multiplier: keeps a K-bit window under each operand's leading one,
// forces the window LSB to 1, multiplies the windows and shifts back.
module drum
   import drum_pkg::*;
#(
   parameter int K = K_DEF,
   parameter int N = N_DEF,
   parameter int M = M_DEF
) (
   input  logic [N-1:0]   a,
   input  logic [M-1:0]   b,
   output logic [N+M-1:0] prod
);

   logic           neg;
   logic [N-1:0]   mag_a;
   logic [M-1:0]   mag_b;
   logic [K-1:0]   frac_a;
   logic [K-1:0]   frac_b;
   int             sh_a;
   int             sh_b;
   logic [2*K-1:0] core;
   logic [N+M-1:0] mag_p;

   // One's-complement magnitude and sign: negative results come out one below the true value.
   assign mag_a = a ^ {N{a[N-1]}};
   assign mag_b = b ^ {M{b[M-1]}};
   assign neg   = a[N-1] ^ b[M-1];

   always_comb begin
      int lead;
      lead = 0;
      for (int i = 0; i < N; i++) begin
         if (mag_a[i]) lead = i;
      end
      if (lead >= K) begin
         sh_a   = lead - K + 1;
         frac_a = K'(mag_a >> sh_a) | K'(1);
      end else begin
         sh_a   = 0;
         frac_a = K'(mag_a);
      end
   end

   always_comb begin
      int lead;
      lead = 0;
      for (int i = 0; i < M; i++) begin
         if (mag_b[i]) lead = i;
      end
      if (lead >= K) begin
         sh_b   = lead - K + 1;
         frac_b = K'(mag_b >> sh_b) | K'(1);
      end else begin
         sh_b   = 0;
         frac_b = K'(mag_b);
      end
   end

   assign core  = (2*K)'(frac_a) * (2*K)'(frac_b);
   assign mag_p = (N+M)'(core) << (sh_a + sh_b);
   assign prod  = mag_p ^ {(N+M){neg}};

endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin pick: lowest requester at or above ptr, otherwise lowest overall.
module rr_arb #(
   parameter int  NREQ = 4,
   localparam int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [PW-1:0]   grant_idx,
   output logic            grant_vld
);

   logic [NREQ-1:0] upper;
   logic [NREQ-1:0] sel;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_mask
         assign upper[gi] = req[gi] && (gi >= int'(ptr));
      end
   endgenerate

   always_comb begin
      sel       = (|upper) ? upper : req;
      grant_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (sel[i]) grant_idx = PW'(i);
      end
      grant_vld = |req;
   end

endmodule

// File: rtl/drum_share_sched.sv
// Round-robin scheduler sharing one DRUM multiplier among NREQ requesters,
// each with a private accumulator; one transaction in flight (IDLE -> MUL -> RSP).
module drum_share_sched
   import drum_pkg::*;
#(
   parameter int  NREQ = 4,
   parameter int  N    = N_DEF,
   parameter int  M    = M_DEF,
   parameter int  K    = K_DEF,
   parameter int  ACCW = 20,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*M-1:0] req_b,
   input  logic [NREQ-1:0]   req_acc,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IW-1:0]     rsp_id,
   output logic [ACCW-1:0]   rsp_data,
   output logic              busy
);

   logic [1:0]             state_reg;
   logic [IW-1:0]          ptr_reg;
   logic [IW-1:0]          ptr_next;
   logic [IW-1:0]          id_reg;
   logic [IW-1:0]          grant_idx;
   logic                   grant_vld;
   logic                   transfer;
   logic [N-1:0]           a_reg;
   logic [M-1:0]           b_reg;
   logic                   flag_reg;
   logic [N-1:0]           a_in [NREQ];
   logic [M-1:0]           b_in [NREQ];
   logic [N+M-1:0]         prod;
   logic signed [ACCW-1:0] prod_ext;
   logic signed [ACCW-1:0] acc_sel;
   logic signed [ACCW-1:0] acc_next;
   logic signed [ACCW-1:0] acc_reg [NREQ];
   logic [ACCW-1:0]        rsp_data_reg;

   // Ready is gated by rst_n so nothing is accepted while reset is held.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign a_in[gi]      = req_a[gi*N +: N];
         assign b_in[gi]      = req_b[gi*M +: M];
         assign req_ready[gi] = rst_n && (state_reg == IDLE) && grant_vld
                                && (grant_idx == IW'(gi));
      end
   endgenerate

   rr_arb #(
      .NREQ(NREQ)
   ) u_arb (
      .req       (req_valid),
      .ptr       (ptr_reg),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   drum #(
      .K(K),
      .N(N),
      .M(M)
   ) u_drum (
      .a    (a_reg),
      .b    (b_reg),
      .prod (prod)
   );

   assign transfer = |(req_valid & req_ready);
   assign ptr_next = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;

   assign prod_ext = ACCW'($signed(prod));
   assign acc_sel  = acc_reg[id_reg];
   assign acc_next = flag_reg ? acc_sel + prod_ext : prod_ext;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         ptr_reg      <= '0;
         id_reg       <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         flag_reg     <= 1'b0;
         rsp_data_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (transfer) begin
                  a_reg     <= a_in[grant_idx];
                  b_reg     <= b_in[grant_idx];
                  flag_reg  <= req_acc[grant_idx];
                  id_reg    <= grant_idx;
                  ptr_reg   <= ptr_next;
                  state_reg <= MUL;
               end
            end
            MUL: begin
               rsp_data_reg <= acc_next;
               state_reg    <= RSP;
            end
            RSP: begin
               if (rsp_ready) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREQ; i++) acc_reg[i] <= '0;
      end else if (state_reg == MUL) begin
         acc_reg[id_reg] <= acc_next;
      end
   end

   assign rsp_valid = (state_reg == RSP);
   assign busy      = (state_reg != IDLE);
   assign rsp_id    = id_reg;
   assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_drum_share_sched.sv
// Directed bench for drum_share_sched: cycle model of the scheduler checked every negedge,
// plus literal expectations for products, accumulation, fairness, backpressure and reset.
module tb_drum_share_sched;

   localparam int NREQ = 4;
   localparam int N    = 8;
   localparam int M    = 8;
   localparam int K    = 3;
   localparam int ACCW = 20;
   localparam int IW   = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*M-1:0] req_b;
   logic [NREQ-1:0]   req_acc;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IW-1:0]     rsp_id;
   logic [ACCW-1:0]   rsp_data;
   logic              busy;

   logic signed [N-1:0] op_a [NREQ];
   logic signed [M-1:0] op_b [NREQ];

   int n_checks = 0;
   int n_fail   = 0;
   int n_txn    = 0;
   int grant_log [8];
   int grant_cnt;

   // model state
   bit     m_init = 1'b0;
   bit     m_after_rst;
   int     m_phase;
   int     m_ptr;
   int     m_id;
   int     m_a;
   int     m_b;
   bit     m_flag;
   longint m_data;
   longint m_acc [NREQ];

   always #5 clk = ~clk;

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*N +: N] = op_a[i];
         req_b[i*M +: M] = op_b[i];
      end
   end

   drum_share_sched #(
      .NREQ(NREQ), .N(N), .M(M), .K(K), .ACCW(ACCW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_acc   (req_acc),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   function void chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Window of K bits under the leading one, odd-forced when truncated.
   function automatic void approx(input int mag, output int f, output int s);
      s = 0;
      f = mag;
      while (f >= (1 << K)) begin
         f = f / 2;
         s++;
      end
      if (s > 0 && (f % 2) == 0) f = f + 1;
   endfunction

   function automatic longint drum_ref(input int a, input int b);
      int     ma, mb, fa, fb, sa, sb;
      bit     neg;
      longint p;
      neg = (a < 0) != (b < 0);
      ma  = (a < 0) ? -a - 1 : a;
      mb  = (b < 0) ? -b - 1 : b;
      approx(ma, fa, sa);
      approx(mb, fb, sb);
      p = longint'(fa) * longint'(fb) * (longint'(1) << (sa + sb));
      return neg ? -p - 1 : p;
   endfunction

   function automatic longint wrapw(input longint v);
      longint r;
      r = v & ((longint'(1) << ACCW) - 1);
      if (r >= (longint'(1) << (ACCW - 1))) r = r - (longint'(1) << ACCW);
      return r;
   endfunction

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   // Cycle model: compare at every negedge, then advance using the inputs seen now.
   initial begin : model
      int               g;
      logic [NREQ-1:0]  er;
      longint           p;
      forever begin
         @(negedge clk);
         g  = -1;
         er = '0;
         if (rst_n && m_init && m_phase == 0) begin
            g = rr_pick(req_valid, m_ptr);
            if (g >= 0) er[g] = 1'b1;
         end
         chk("m_req_ready", longint'(req_ready), longint'(er));
         if (m_init) begin
            chk("m_busy", longint'(busy), longint'(m_phase != 0));
            chk("m_rsp_valid", longint'(rsp_valid), longint'(m_phase == 2));
            if (m_phase == 2 || m_after_rst) begin
               chk("m_rsp_id", longint'(rsp_id), longint'(m_id));
               chk("m_rsp_data", longint'($signed(rsp_data)), m_data);
            end
         end
         if (!rst_n) begin
            m_init      = 1'b1;
            m_after_rst = 1'b1;
            m_phase     = 0;
            m_ptr       = 0;
            m_id        = 0;
            m_data      = 0;
            for (int i = 0; i < NREQ; i++) m_acc[i] = 0;
         end else if (m_init) begin
            case (m_phase)
               0: if (g >= 0) begin
                  m_id        = g;
                  m_a         = int'(op_a[g]);
                  m_b         = int'(op_b[g]);
                  m_flag      = req_acc[g];
                  m_ptr       = (g + 1) % NREQ;
                  m_phase     = 1;
                  m_after_rst = 1'b0;
               end
               1: begin
                  p = drum_ref(m_a, m_b);
                  m_acc[m_id] = m_flag ? wrapw(m_acc[m_id] + p) : wrapw(p);
                  m_data      = m_acc[m_id];
                  m_phase     = 2;
               end
               default: if (rsp_ready) begin
                  n_txn++;
                  $display("txn %0d: id=%0d a=%0d b=%0d acc=%0d -> data=%0d",
                           n_txn, m_id, m_a, m_b, m_flag, m_data);
                  m_phase = 0;
               end
            endcase
         end
      end
   end

   // Called just after a posedge; holds reset for two edges.
   task automatic apply_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      @(negedge clk);
      chk("rst_req_ready_pre", longint'(req_ready), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_req_ready", longint'(req_ready), 0);
      chk("rst_rsp_valid", longint'(rsp_valid), 0);
      chk("rst_rsp_id", longint'(rsp_id), 0);
      chk("rst_rsp_data", longint'(rsp_data), 0);
      chk("rst_busy", longint'(busy), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Called just after a posedge; returns just after the response handshake edge.
   task automatic run_txn(input int id, input int a, input int b, input bit acc,
                          input longint exp, input int stall, input int side);
      bit seen;
      int lat;
      op_a[id]      = N'(a);
      op_b[id]      = M'(b);
      req_acc[id]   = acc;
      req_valid[id] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         if (req_valid[id] && req_ready[id]) seen = 1'b1;
      end
      chk("accept", longint'(seen), 1);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      if (side >= 0) begin
         op_a[side]      = 1;
         op_b[side]      = 1;
         req_acc[side]   = 1'b1;
         req_valid[side] = 1'b1;
      end
      rsp_ready = (stall == 0);
      seen = 1'b0;
      lat  = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) seen = 1'b1;
      end
      chk("latency", longint'(lat), 2);
      chk("rsp_id", longint'(rsp_id), longint'(id));
      chk("rsp_data", longint'($signed(rsp_data)), exp);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("stall_rsp_valid", longint'(rsp_valid), 1);
         chk("stall_rsp_id", longint'(rsp_id), longint'(id));
         chk("stall_rsp_data", longint'($signed(rsp_data)), exp);
         chk("stall_req_ready", longint'(req_ready), 0);
      end
      if (stall > 0) begin
         @(posedge clk); #1;
         rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (!busy && !rsp_valid) done = 1'b1;
      end
      chk("idle_timeout", longint'(done), 1);
      @(posedge clk); #1;
   endtask

   task automatic collect_grants(input int count, input bit drop_each);
      int g;
      grant_cnt = 0;
      for (int c = 0; c < 100 && grant_cnt < count; c++) begin
         @(negedge clk);
         g = -1;
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) g = i;
         end
         @(posedge clk); #1;
         if (g >= 0) begin
            grant_log[grant_cnt] = g;
            grant_cnt++;
            if (drop_each) req_valid[g] = 1'b0;
            if (grant_cnt == count) req_valid = '0;
         end
      end
      chk("grant_count", longint'(grant_cnt), longint'(count));
      req_valid = '0;
      wait_idle();
   endtask

   initial begin : main
      int exp_fair [5];
      int exp_ptr  [2];
      exp_fair = '{0, 1, 2, 3, 0};
      exp_ptr  = '{3, 0};
      rsp_ready = 1'b1;
      req_valid = '0;
      req_acc   = '0;
      for (int i = 0; i < NREQ; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      apply_reset();

      run_txn(0, 3, 5, 1'b0, 15, 0, -1);
      run_txn(0, 100, 100, 1'b0, 12544, 0, -1);
      run_txn(0, -3, 5, 1'b0, -11, 0, -1);
      run_txn(1, 1, 1, 1'b0, 1, 0, -1);
      run_txn(2, 3, 5, 1'b0, 15, 0, -1);
      run_txn(2, 3, 5, 1'b1, 30, 0, -1);
      run_txn(1, 1, 1, 1'b1, 2, 0, -1);
      run_txn(3, 0, -1, 1'b0, -1, 0, -1);
      run_txn(3, -3, -5, 1'b1, 7, 0, -1);
      run_txn(3, 127, -128, 1'b0, -12545, 0, -1);

      // backpressure with requester 1 waiting, then it is served
      run_txn(3, 2, 2, 1'b0, 4, 5, 1);
      run_txn(1, 1, 1, 1'b1, 3, 0, -1);

      // reset while a product is in flight
      op_a[0]      = 7;
      op_b[0]      = 7;
      req_acc[0]   = 1'b0;
      req_valid[0] = 1'b1;
      @(negedge clk);
      chk("mid_accept", longint'(req_ready[0]), 1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      apply_reset();
      run_txn(0, 3, 5, 1'b1, 15, 0, -1);
      run_txn(1, 1, 1, 1'b1, 1, 0, -1);

      // fairness from ptr=0 with everyone asking continuously
      apply_reset();
      for (int i = 0; i < NREQ; i++) begin
         op_a[i]    = N'(i + 1);
         op_b[i]    = 2;
         req_acc[i] = 1'b0;
      end
      req_valid = '1;
      collect_grants(5, 1'b0);
      for (int i = 0; i < 5; i++) chk("fair_order", longint'(grant_log[i]), longint'(exp_fair[i]));

      // simultaneous 0 and 3 with ptr=1: 3 wins first
      op_a[0]   = 5;
      op_b[0]   = 5;
      op_a[3]   = -2;
      op_b[3]   = 3;
      req_acc   = '0;
      req_valid = 4'b1001;
      collect_grants(2, 1'b1);
      for (int i = 0; i < 2; i++) chk("ptr_order", longint'(grant_log[i]), longint'(exp_ptr[i]));

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
